multi_source_delayed_trigger: RTL
=================================

# multi_source_delayed_trigger

Parametrised successor to the fixed 8-DIO/2-ADC counter-delayed trigger. Measures the period between edges of a selectable DIO or ADC-threshold source and, once armed, raises `trigger` a programmable number of cycles (`presamples`) before the next expected edge. It adds parametrised channel counts, selectable edge polarity, ADC threshold crossing with hysteresis, and glitch-free source switching. It sits between the DIO/ADC front end and the acquisition write logic in the PL.

## Interface
- `COUNTER_WIDTH`, 32, width of the period counter, `reference_counter` and `last_counter`
- `PRESAMPLE_WIDTH`, 32, width of `presamples`
- `NUM_DIO`, 8, number of DIO inputs (1..16)
- `NUM_ADC`, 2, number of ADC channels (1..16)
- `ADC_WIDTH`, 16, ADC sample width, two's complement
- `clk` in 1: single clock domain
- `aresetn` in 1: asynchronous, active-low reset
- `enable` in 1: block enable, level
- `arm` in 1: arm request, sampled every cycle
- `trigger_reset` in 1: clear fired or armed state
- `dios` in NUM_DIO: asynchronous digital inputs
- `adc_data` in NUM_ADC*ADC_WIDTH: channel i at `[i*ADC_WIDTH +: ADC_WIDTH]`
- `source_select` in 5: bit4 0=DIO, 1=ADC; bits[3:0] channel index
- `edge_falling` in 1: 0=rising-edge events, 1=falling-edge events
- `threshold_hi`, `threshold_lo` in ADC_WIDTH: signed hysteresis thresholds
- `presamples` in PRESAMPLE_WIDTH: lead of trigger before expected edge
- `reference_counter` in COUNTER_WIDTH: expected period in cycles
- `trigger` out 1: delayed trigger, held until cleared
- `armed_status` out 1: high in WAIT_SYNC or COUNTING
- `last_counter` out COUNTER_WIDTH: last measured edge-to-edge period
- `event_pulse` out 1: one-cycle pulse per detected source edge

## Operation
- DIO path: 2-FF synchroniser per bit, then selected bit to edge detector.
- ADC path: per selected channel, registered level: set when `adc >= threshold_hi` (signed), cleared when `adc < threshold_lo`, otherwise held; level reset 0.
- Edge detector: event when level goes 0→1 (`edge_falling`=0) or 1→0 (`edge_falling`=1).
- Channel index ≥ NUM_DIO or NUM_ADC: level forced 0, no events.
- `source_select` or `edge_falling` changes: event suppressed in that cycle and the next; edge history reloads from the new source.
- Period counter: +1 per cycle while `enable`, saturates at all-ones. On event: `last_counter <= counter+1` (saturating), `counter <= 0`.
- `fire_point` = `reference_counter - presamples` if `reference_counter > presamples`, else 0; widths zero-extended to max width.
- FSM states:
  - DISARMED → WAIT_SYNC on `arm`.
  - WAIT_SYNC → COUNTING on event.
  - COUNTING → FIRED when `counter == fire_point`. An event before that restarts the counter and stays in COUNTING.
  - FIRED: holds until `trigger_reset`; `arm` ignored.
- `trigger_reset` in any state → DISARMED. It wins over a simultaneous `arm` or fire condition.
- `enable`=0: FSM forced DISARMED, counter held at 0, `last_counter` retained, `event_pulse` 0.
- `trigger` = registered (state == FIRED).

## Timing
- Reset values: `trigger` 0, `armed_status` 0, `last_counter` 0, `event_pulse` 0, counter 0, FSM DISARMED, synchronisers and ADC level 0.
- DIO pin edge → `event_pulse`: 3 cycles. ADC sample → `event_pulse`: 2 cycles.
- Event in cycle E → counter = k in cycle E+1+k. `trigger` rises in cycle E+2+fire_point.
- `arm` → `armed_status`: 1 cycle. `trigger_reset` → `trigger` low: 1 cycle.
- `last_counter` updates 1 cycle after `event_pulse`.
- Deassertion of `aresetn` mid-operation: all state returns to reset values immediately. The first event after reset reports `last_counter` = cycles since reset+1.
- `reference_counter` and `presamples` are used live. A change mid-period takes effect on the next comparison.

## Test plan
- Unarmed period measurement: DIO0 rising every 128 cycles → `last_counter` = 128 after the 2nd edge, `trigger` stays 0, `armed_status` 0.
- Armed delayed fire: period 128, `reference_counter`=130, `presamples`=10, pulse `arm` → `armed_status` 1. After the next sync edge in cycle E, `trigger` rises in cycle E+122, `armed_status` drops, and `trigger` holds through later edges until `trigger_reset`.
- Clamp and reset precedence: `presamples`=200 > `reference_counter`=130 → `trigger` at E+2. `arm` and `trigger_reset` in the same cycle → stays DISARMED.
- ADC hysteresis: ch1 ramp, `threshold_hi`=1000, `threshold_lo`=500, source ADC ch1. Noise between 500 and 1000 yields no events; a clean crossing yields exactly one `event_pulse`. With `edge_falling`=1, the event fires on the drop below 500.
- Source switch and invalid index: switch DIO0→DIO3 while DIO3 is high → no spurious event. Index 12 with NUM_DIO=8 → no events.
- Enable and reset: `enable`=0 mid-COUNTING → DISARMED, `last_counter` retained. `aresetn` low mid-FIRED → all outputs 0 immediately.

Source files
------------

// File: rtl/multi_source_delayed_trigger.sv
// rtl/multi_source_delayed_trigger.sv - period-measuring trigger that fires a set lead ahead of the next DIO/ADC edge
// Source edges restart a period counter; once armed, trigger rises when the counter reaches the fire point.
module multi_source_delayed_trigger #(
  parameter int COUNTER_WIDTH   = 32,
  parameter int PRESAMPLE_WIDTH = 32,
  parameter int NUM_DIO         = 8,
  parameter int NUM_ADC         = 2,
  parameter int ADC_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic                         enable,
  input  logic                         arm,
  input  logic                         trigger_reset,
  input  logic [NUM_DIO-1:0]           dios,
  input  logic [NUM_ADC*ADC_WIDTH-1:0] adc_data,
  input  logic [4:0]                   source_select,
  input  logic                         edge_falling,
  input  logic [ADC_WIDTH-1:0]         threshold_hi,
  input  logic [ADC_WIDTH-1:0]         threshold_lo,
  input  logic [PRESAMPLE_WIDTH-1:0]   presamples,
  input  logic [COUNTER_WIDTH-1:0]     reference_counter,
  output logic                         trigger,
  output logic                         armed_status,
  output logic [COUNTER_WIDTH-1:0]     last_counter,
  output logic                         event_pulse
);

  localparam int FW = (COUNTER_WIDTH > PRESAMPLE_WIDTH) ? COUNTER_WIDTH : PRESAMPLE_WIDTH;

  typedef enum logic [1:0] {DISARMED, WAIT_SYNC, COUNTING, FIRED} state_t;

  state_t                   state;
  logic [NUM_DIO-1:0]       dio_meta;
  logic [NUM_DIO-1:0]       dio_sync;
  logic [NUM_ADC-1:0]       adc_level;
  logic                     src_level;
  logic                     prev_level;
  logic [4:0]               prev_select;
  logic                     prev_falling;
  logic                     sel_changed;
  logic                     sel_changed_d;
  logic                     suppress;
  logic                     event_hit;
  logic [COUNTER_WIDTH-1:0] counter;
  logic [COUNTER_WIDTH-1:0] counter_inc;
  logic [FW-1:0]            ref_ext;
  logic [FW-1:0]            pre_ext;
  logic [FW-1:0]            fire_point;
  logic                     at_fire_point;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      dio_meta <= '0;
      dio_sync <= '0;
    end else begin
      dio_meta <= dios;
      dio_sync <= dio_meta;
    end
  end

  // Every channel keeps its own hysteresis level so a source switch sees settled history.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      adc_level <= '0;
    end else begin
      for (int i = 0; i < NUM_ADC; i++) begin
        if ($signed(adc_data[i*ADC_WIDTH +: ADC_WIDTH]) >= $signed(threshold_hi))
          adc_level[i] <= 1'b1;
        else if ($signed(adc_data[i*ADC_WIDTH +: ADC_WIDTH]) < $signed(threshold_lo))
          adc_level[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    src_level = 1'b0;
    if (source_select[4]) begin
      for (int i = 0; i < NUM_ADC; i++)
        if (source_select[3:0] == 4'(i)) src_level = adc_level[i];
    end else begin
      for (int i = 0; i < NUM_DIO; i++)
        if (source_select[3:0] == 4'(i)) src_level = dio_sync[i];
    end
  end

  // Blank detection for the cycle of a selection change and the one after it.
  assign sel_changed = (source_select != prev_select) || (edge_falling != prev_falling);
  assign suppress    = sel_changed || sel_changed_d;
  assign event_hit   = !suppress &&
                       (edge_falling ? (prev_level && !src_level) : (src_level && !prev_level));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      prev_level    <= 1'b0;
      prev_select   <= '0;
      prev_falling  <= 1'b0;
      sel_changed_d <= 1'b0;
      event_pulse   <= 1'b0;
    end else begin
      prev_level    <= src_level;
      prev_select   <= source_select;
      prev_falling  <= edge_falling;
      sel_changed_d <= sel_changed;
      event_pulse   <= enable && event_hit;
    end
  end

  assign counter_inc = (&counter) ? counter : counter + COUNTER_WIDTH'(1);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      counter      <= '0;
      last_counter <= '0;
    end else if (!enable) begin
      counter <= '0;
    end else if (event_pulse) begin
      counter      <= '0;
      last_counter <= counter_inc;
    end else begin
      counter <= counter_inc;
    end
  end

  assign ref_ext       = FW'(reference_counter);
  assign pre_ext       = FW'(presamples);
  assign fire_point    = (ref_ext > pre_ext) ? (ref_ext - pre_ext) : '0;
  assign at_fire_point = (FW'(counter) == fire_point);

  // trigger and armed_status are set together with the state they decode.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= DISARMED;
      trigger      <= 1'b0;
      armed_status <= 1'b0;
    end else if (!enable || trigger_reset) begin
      state        <= DISARMED;
      trigger      <= 1'b0;
      armed_status <= 1'b0;
    end else begin
      case (state)
        DISARMED: begin
          if (arm) begin
            state        <= WAIT_SYNC;
            armed_status <= 1'b1;
          end
        end
        WAIT_SYNC: begin
          if (event_pulse) state <= COUNTING;
        end
        COUNTING: begin
          if (at_fire_point) begin
            state        <= FIRED;
            trigger      <= 1'b1;
            armed_status <= 1'b0;
          end
        end
        FIRED: begin
          trigger <= 1'b1;
        end
        default: begin
          state        <= DISARMED;
          trigger      <= 1'b0;
          armed_status <= 1'b0;
        end
      endcase
    end
  end

endmodule
